// File: rtl/psum_accum_sfu.sv
// Partial-sum accumulator / special-function stage: pops MAC-array FIFO words, accumulates
// num_k kernel positions per pixel and column, then drains per-pixel results with optional ReLU.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | request one FIFO word when the FIFO has one
// WAIT  | read latency countdown; accumulate the word on the last cycle
// DRAIN | present one pixel per handshake on the output port
// DONE  | one-cycle completion pulse
module psum_accum_sfu #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int acc_bw  = 20,
   parameter int num_pix = 16,
   parameter int num_k   = 9,
   parameter int rd_lat  = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic                        relu_en,
   input  logic                        ofifo_valid,
   input  logic [col*psum_bw-1:0]      ofifo_out,
   output logic                        ofifo_rd,
   output logic [col*acc_bw-1:0]       out_data,
   output logic [$clog2(num_pix)-1:0]  out_pix,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        busy,
   output logic                        done
);

   localparam int pix_w = $clog2(num_pix);
   localparam int k_w   = (num_k > 1) ? $clog2(num_k) : 1;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, DONE} state_t;

   state_t            state, state_nxt;
   logic [pix_w-1:0]  pix_cnt;
   logic [k_w-1:0]    k_cnt;
   logic [1:0]        lat_cnt;
   logic              relu_q;
   logic [acc_bw-1:0] acc [num_pix][col];

   logic take, last_pix, last_k;

   assign take     = (state == WAIT) && (lat_cnt == 2'd1);
   assign last_pix = (pix_cnt == pix_w'(num_pix - 1));
   assign last_k   = (k_cnt == k_w'(num_k - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         pix_cnt <= '0;
         k_cnt   <= '0;
         lat_cnt <= '0;
         relu_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (start) begin
                  relu_q  <= relu_en;
                  pix_cnt <= '0;
                  k_cnt   <= '0;
                  lat_cnt <= '0;
               end
            end
            ISSUE: begin
               if (ofifo_valid) lat_cnt <= 2'(rd_lat);
            end
            WAIT: begin
               lat_cnt <= lat_cnt - 1'b1;
               if (take) begin
                  if (last_pix) begin
                     pix_cnt <= '0;
                     k_cnt   <= last_k ? '0 : k_cnt + 1'b1;
                  end else begin
                     pix_cnt <= pix_cnt + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (out_ready) pix_cnt <= last_pix ? '0 : pix_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // First kernel position overwrites, so stale contents from an aborted pass never leak in.
   always_ff @(posedge clk) begin
      if (take) begin
         for (int i = 0; i < col; i++) begin
            acc[pix_cnt][i] <= ((k_cnt == '0) ? '0 : acc[pix_cnt][i])
               + {{(acc_bw-psum_bw){ofifo_out[i*psum_bw+psum_bw-1]}}, ofifo_out[i*psum_bw +: psum_bw]};
         end
      end
   end

   always_comb begin
      state_nxt = state;
      ofifo_rd  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = ISSUE;
         end
         ISSUE: begin
            busy = 1'b1;
            if (ofifo_valid) begin
               ofifo_rd  = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            busy = 1'b1;
            if (take) state_nxt = (last_pix && last_k) ? DRAIN : ISSUE;
         end
         DRAIN: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready && last_pix) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      out_data = '0;
      out_pix  = '0;
      if (state == DRAIN) begin
         out_pix = pix_cnt;
         for (int i = 0; i < col; i++) begin
            out_data[i*acc_bw +: acc_bw] = (relu_q && acc[pix_cnt][i][acc_bw-1]) ? '0 : acc[pix_cnt][i];
         end
      end
   end

endmodule

// File: tb/tb_psum_accum_sfu.sv
// Randomized bench for psum_accum_sfu: FIFO model with read latency, backpressure, and an
// arithmetic reference (sum of signed lanes, wrapped to acc_bw, optional ReLU).
module tb_psum_accum_sfu;

   localparam int col     = 4;
   localparam int psum_bw = 16;
   localparam int acc_bw  = 17;
   localparam int num_pix = 4;
   localparam int num_k   = 3;
   localparam int rd_lat  = 2;
   localparam int nw      = num_pix * num_k;
   localparam int w_in    = col * psum_bw;
   localparam int w_out   = col * acc_bw;

   logic                       clk, reset, start, relu_en, ofifo_valid, ofifo_rd;
   logic [w_in-1:0]            ofifo_out;
   logic [w_out-1:0]           out_data;
   logic [$clog2(num_pix)-1:0] out_pix;
   logic                       out_valid, out_ready, busy, done;

   psum_accum_sfu #(.col(col), .psum_bw(psum_bw), .acc_bw(acc_bw), .num_pix(num_pix),
                    .num_k(num_k), .rd_lat(rd_lat)) dut (
      .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
      .ofifo_valid(ofifo_valid), .ofifo_out(ofifo_out), .ofifo_rd(ofifo_rd),
      .out_data(out_data), .out_pix(out_pix), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .done(done));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference model state
   logic [w_in-1:0]  q[$];
   logic [w_out-1:0] exp_word [num_pix];

   int vmode, rmode, rd_cnt, drain_cnt, done_cnt;

   function automatic logic [w_in-1:0] junk();
      logic [w_in-1:0] j;
      for (int b = 0; b < w_in; b += 32) j[b +: 32] = $urandom;
      return j;
   endfunction

   // kind: 0 random, 1 all +5, 2 relu pattern, 3 all +32767
   task automatic build(input int kind, input bit relu);
      longint          sum [num_pix][col];
      logic [w_in-1:0] word;
      logic [acc_bw-1:0] r;
      int v;
      q.delete();
      for (int p = 0; p < num_pix; p++)
         for (int i = 0; i < col; i++) sum[p][i] = 0;
      for (int k = 0; k < num_k; k++) begin
         for (int p = 0; p < num_pix; p++) begin
            for (int i = 0; i < col; i++) begin
               case (kind)
                  1: v = 5;
                  2: begin
                     if (p == 0)      v = (k == 0) ? -7 : (k == 1) ? 2 : 0;
                     else if (p == 1) v = (k == 0) ? 3 : (k == 1) ? 4 : 0;
                     else             v = int'($urandom_range(0, 65535)) - 32768;
                  end
                  3: v = 32767;
                  default: v = int'($urandom_range(0, 65535)) - 32768;
               endcase
               word[i*psum_bw +: psum_bw] = psum_bw'(v);
               sum[p][i] += v;
            end
            q.push_back(word);
         end
      end
      for (int p = 0; p < num_pix; p++)
         for (int i = 0; i < col; i++) begin
            r = acc_bw'(sum[p][i]);
            if (relu && r[acc_bw-1]) r = '0;
            exp_word[p][i*acc_bw +: acc_bw] = r;
         end
   endtask

   // FIFO / sink model and protocol monitor
   initial begin
      int              cd = 0, cyc = 0, last_rd_cyc = 0, vphase = 0, rwait = 0;
      bit              prev_hold = 0;
      logic [w_in-1:0] cur_word = '0;
      logic [w_out-1:0] prev_data = '0;
      logic [$clog2(num_pix)-1:0] prev_pix = '0;
      ofifo_valid = 1'b0;
      out_ready   = 1'b0;
      ofifo_out   = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (cd != 0) begin
            cd--;
            ofifo_out = (cd == 0) ? cur_word : junk();
         end else begin
            ofifo_out = junk();
         end
         vphase = (vphase + 1) % 4;
         ofifo_valid = (q.size() > 0) && (vmode == 0 || (vmode == 1 && vphase == 0) ||
                       (vmode == 2 && $urandom_range(0, 1) == 1));
         out_ready = (rmode == 0) || (rmode == 1 && rwait >= 5) ||
                     (rmode == 2 && $urandom_range(0, 1) == 1);
         #1;
         if (reset) begin
            cd = 0;
            prev_hold = 0;
         end else begin
            if (ofifo_rd) begin
               chk("rd_valid", ofifo_valid, 1);
               chk("rd_in_wait", cd, 0);
               if (rd_cnt > 0) chk("rd_spacing", (cyc - last_rd_cyc) >= rd_lat + 1, 1);
               last_rd_cyc = cyc;
               rd_cnt++;
               cur_word = (q.size() > 0) ? q.pop_front() : junk();
               cd = rd_lat;
            end
            if (prev_hold) begin
               chk("hold_valid", out_valid, 1);
               chk("hold_pix", out_pix, prev_pix);
               chk("hold_data", out_data, prev_data);
            end
            if (out_valid) begin
               if (out_ready) begin
                  chk("out_pix", out_pix, drain_cnt % num_pix);
                  chk("out_data", out_data, exp_word[drain_cnt % num_pix]);
                  drain_cnt++;
                  rwait = 0;
               end else begin
                  rwait++;
               end
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            prev_pix  = out_pix;
            if (done) begin
               chk("done_after_drain", drain_cnt, num_pix);
               chk("done_busy", busy, 0);
               done_cnt++;
            end
         end
      end
   end

   task automatic chk_idle(input string tag);
      chk({tag, "_rd"}, ofifo_rd, 0);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_pix"}, out_pix, 0);
      chk({tag, "_data"}, out_data, 0);
   endtask

   task automatic run_pass(input int kind, input bit relu, input int vm, input int rm,
                           input bit poke);
      build(kind, relu);
      vmode = vm;
      rmode = rm;
      rd_cnt = 0;
      drain_cnt = 0;
      done_cnt = 0;
      @(negedge clk);
      start = 1'b1;
      relu_en = relu;
      @(negedge clk);
      start = 1'b0;
      relu_en = ~relu;
      if (poke) begin
         repeat (10) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      for (int c = 0; c < 3000 && done_cnt == 0; c++) @(negedge clk);
      chk("pass_timeout", done_cnt != 0, 1);
      repeat (10) @(negedge clk);
      chk("done_count", done_cnt, 1);
      chk("reads", rd_cnt, nw);
      chk("drained", drain_cnt, num_pix);
   endtask

   initial begin
      vmode = 0;
      rmode = 0;
      rd_cnt = 0;
      drain_cnt = 0;
      done_cnt = 0;
      reset = 1'b1;
      start = 1'b0;
      relu_en = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      chk_idle("reset");
      reset = 1'b0;

      run_pass(1, 0, 0, 0, 0);   // +5 everywhere -> 15
      run_pass(2, 1, 0, 0, 0);   // relu on: pixel0 -> 0, pixel1 -> 7
      run_pass(2, 0, 0, 0, 0);   // relu off: pixel0 -> -5
      run_pass(0, 0, 1, 0, 0);   // FIFO stalls
      run_pass(0, 1, 1, 0, 0);
      run_pass(0, 0, 0, 1, 0);   // backpressure
      run_pass(3, 0, 0, 0, 0);   // wrap -> -32771
      run_pass(3, 1, 0, 0, 0);   // wrap with relu -> 0
      for (int n = 0; n < 6; n++) run_pass(0, 1'($urandom), 2, 2, 1);

      // abort mid-pass while stalled in ISSUE after five reads
      build(0, 0);
      while (q.size() > 5) void'(q.pop_back());
      vmode = 0;
      rmode = 0;
      rd_cnt = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 200 && rd_cnt < 5; c++) @(negedge clk);
      chk("abort_reads", rd_cnt, 5);
      repeat (rd_lat + 3) @(negedge clk);
      chk("abort_busy", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      #2;
      chk_idle("abort");
      reset = 1'b0;
      q.delete();
      run_pass(0, 0, 0, 0, 0);
      run_pass(0, 1, 2, 2, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
